hpdcache_cmo_dispatch: RTL and testbench



---
 rtl/hpdcache_pkg.sv | 36 +++
 rtl/hpdcache_cmo_dispatch.sv | 131 +++++++++++++
 tb/tb_hpdcache_cmo_dispatch.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_pkg.sv
// Shared hpdcache types: CMO opcode encoding and the one-hot handler operation.
package hpdcache_pkg;

   localparam int unsigned HPDCACHE_CMO_OPCODE_WIDTH = 3;

   typedef enum logic [HPDCACHE_CMO_OPCODE_WIDTH-1:0] {
      HPDCACHE_CMO_FENCE           = 3'b000,
      HPDCACHE_CMO_INVAL_NLINE     = 3'b001,
      HPDCACHE_CMO_INVAL_SET       = 3'b010,
      HPDCACHE_CMO_INVAL_ALL       = 3'b011
   } hpdcache_cmo_opcode_t;

   typedef struct packed {
      logic is_inval_all;
      logic is_inval_by_set;
      logic is_inval_by_nline;
      logic is_fence;
   } hpdcache_cmoh_op_t;

   // Illegal opcodes decode to an all-zero operation
   function automatic hpdcache_cmoh_op_t hpdcache_cmo_opcode_decode(
      input logic [HPDCACHE_CMO_OPCODE_WIDTH-1:0] opcode
   );
      hpdcache_cmoh_op_t op;
      op = '0;
      case (opcode)
         HPDCACHE_CMO_FENCE:       op.is_fence          = 1'b1;
         HPDCACHE_CMO_INVAL_NLINE: op.is_inval_by_nline = 1'b1;
         HPDCACHE_CMO_INVAL_SET:   op.is_inval_by_set   = 1'b1;
         HPDCACHE_CMO_INVAL_ALL:   op.is_inval_all      = 1'b1;
         default:                  op                   = '0;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/hpdcache_cmo_dispatch.sv
// CMO request front end: accepts one core CMO at a time, issues it to the CMO
// handler, tracks completion through the handler ready, and returns a response.
module hpdcache_cmo_dispatch
   import hpdcache_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 49,
   parameter int unsigned WDATA_WIDTH = 64,
   parameter int unsigned SID_WIDTH   = 3,
   parameter int unsigned TID_WIDTH   = 6
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,

   input  logic                                 core_req_valid_i,
   output logic                                 core_req_ready_o,
   input  logic [HPDCACHE_CMO_OPCODE_WIDTH-1:0] core_req_opcode_i,
   input  logic [ADDR_WIDTH-1:0]                core_req_addr_i,
   input  logic [WDATA_WIDTH-1:0]               core_req_wdata_i,
   input  logic [SID_WIDTH-1:0]                 core_req_sid_i,
   input  logic [TID_WIDTH-1:0]                 core_req_tid_i,
   input  logic                                 core_req_need_rsp_i,

   output logic                                 cmo_req_valid_o,
   input  logic                                 cmo_req_ready_i,
   output logic [3:0]                           cmo_req_op_o,
   output logic [ADDR_WIDTH-1:0]                cmo_req_addr_o,
   output logic [WDATA_WIDTH-1:0]               cmo_req_wdata_o,

   output logic                                 core_rsp_valid_o,
   input  logic                                 core_rsp_ready_i,
   output logic [SID_WIDTH-1:0]                 core_rsp_sid_o,
   output logic [TID_WIDTH-1:0]                 core_rsp_tid_o,
   output logic                                 core_rsp_error_o
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_DONE,
      RSP
   } state_t;

   state_t            state_q;
   hpdcache_cmoh_op_t op_q;
   logic              need_rsp_q;
   logic              accept;
   logic              illegal;

   assign accept  = core_req_ready_o & core_req_valid_i;
   assign illegal = (core_req_opcode_i > 3'd3);

   assign cmo_req_op_o = cmo_req_valid_o ? op_q : '0;

   // Payload is only meaningful while the FSM is past IDLE, so it is not reset
   always_ff @(posedge clk_i) begin
      if (accept) begin
         op_q            <= hpdcache_cmo_opcode_decode(core_req_opcode_i);
         cmo_req_addr_o  <= core_req_addr_i;
         cmo_req_wdata_o <= core_req_wdata_i;
         core_rsp_sid_o  <= core_req_sid_i;
         core_rsp_tid_o  <= core_req_tid_i;
         need_rsp_q      <= core_req_need_rsp_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q          <= IDLE;
         core_req_ready_o <= 1'b1;
         cmo_req_valid_o  <= 1'b0;
         core_rsp_valid_o <= 1'b0;
         core_rsp_error_o <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (core_req_valid_i) begin
                  core_rsp_error_o <= illegal;
                  if (!illegal) begin
                     state_q          <= ISSUE;
                     core_req_ready_o <= 1'b0;
                     cmo_req_valid_o  <= 1'b1;
                  end else if (core_req_need_rsp_i) begin
                     state_q          <= RSP;
                     core_req_ready_o <= 1'b0;
                     core_rsp_valid_o <= 1'b1;
                  end
               end
            end

            ISSUE: begin
               if (cmo_req_ready_i) begin
                  state_q         <= WAIT_START;
                  cmo_req_valid_o <= 1'b0;
               end
            end

            // Handler ready may still read high here before it goes busy
            WAIT_START: state_q <= WAIT_DONE;

            WAIT_DONE: begin
               if (cmo_req_ready_i) begin
                  if (need_rsp_q) begin
                     state_q          <= RSP;
                     core_rsp_valid_o <= 1'b1;
                  end else begin
                     state_q          <= IDLE;
                     core_req_ready_o <= 1'b1;
                  end
               end
            end

            RSP: begin
               if (core_rsp_ready_i) begin
                  state_q          <= IDLE;
                  core_rsp_valid_o <= 1'b0;
                  core_req_ready_o <= 1'b1;
               end
            end

            default: begin
               state_q          <= IDLE;
               core_req_ready_o <= 1'b1;
               cmo_req_valid_o  <= 1'b0;
               core_rsp_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hpdcache_cmo_dispatch.sv
// Self-checking bench for hpdcache_cmo_dispatch: directed scenarios plus a
// randomized transaction run against a cycle-latency reference model.
module tb_hpdcache_cmo_dispatch;
   import hpdcache_pkg::*;

   localparam int unsigned AW = 49;
   localparam int unsigned WW = 64;
   localparam int unsigned SW = 3;
   localparam int unsigned TW = 6;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          core_req_valid_i = 1'b0;
   logic          core_req_ready_o;
   logic [2:0]    core_req_opcode_i = '0;
   logic [AW-1:0] core_req_addr_i = '0;
   logic [WW-1:0] core_req_wdata_i = '0;
   logic [SW-1:0] core_req_sid_i = '0;
   logic [TW-1:0] core_req_tid_i = '0;
   logic          core_req_need_rsp_i = 1'b0;
   logic          cmo_req_valid_o;
   logic          cmo_req_ready_i = 1'b1;
   logic [3:0]    cmo_req_op_o;
   logic [AW-1:0] cmo_req_addr_o;
   logic [WW-1:0] cmo_req_wdata_o;
   logic          core_rsp_valid_o;
   logic          core_rsp_ready_i = 1'b0;
   logic [SW-1:0] core_rsp_sid_o;
   logic [TW-1:0] core_rsp_tid_o;
   logic          core_rsp_error_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   hpdcache_cmo_dispatch #(
      .ADDR_WIDTH (AW),
      .WDATA_WIDTH(WW),
      .SID_WIDTH  (SW),
      .TID_WIDTH  (TW)
   ) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .core_req_valid_i   (core_req_valid_i),
      .core_req_ready_o   (core_req_ready_o),
      .core_req_opcode_i  (core_req_opcode_i),
      .core_req_addr_i    (core_req_addr_i),
      .core_req_wdata_i   (core_req_wdata_i),
      .core_req_sid_i     (core_req_sid_i),
      .core_req_tid_i     (core_req_tid_i),
      .core_req_need_rsp_i(core_req_need_rsp_i),
      .cmo_req_valid_o    (cmo_req_valid_o),
      .cmo_req_ready_i    (cmo_req_ready_i),
      .cmo_req_op_o       (cmo_req_op_o),
      .cmo_req_addr_o     (cmo_req_addr_o),
      .cmo_req_wdata_o    (cmo_req_wdata_o),
      .core_rsp_valid_o   (core_rsp_valid_o),
      .core_rsp_ready_i   (core_rsp_ready_i),
      .core_rsp_sid_o     (core_rsp_sid_o),
      .core_rsp_tid_o     (core_rsp_tid_o),
      .core_rsp_error_o   (core_rsp_error_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Stimulus only: presents a request at the current negedge, returns its cycle index
   task automatic drive_req(input logic [2:0] opc, input logic [AW-1:0] ad, input logic [WW-1:0] wd,
                            input logic [SW-1:0] sd, input logic [TW-1:0] td, input logic nr,
                            output int acc);
      core_req_valid_i    = 1'b1;
      core_req_opcode_i   = opc;
      core_req_addr_i     = ad;
      core_req_wdata_i    = wd;
      core_req_sid_i      = sd;
      core_req_tid_i      = td;
      core_req_need_rsp_i = nr;
      acc = cyc;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      total++; if (core_req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", core_req_ready_o); end
      total++; if (cmo_req_valid_o !== 1'b0) begin bad++; $display("FAIL reset_cmo_valid got=%b exp=0", cmo_req_valid_o); end
      total++; if (core_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", core_rsp_valid_o); end
      total++; if (core_rsp_error_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_error got=%b exp=0", core_rsp_error_o); end
      total++; if (cmo_req_op_o !== 4'b0000) begin bad++; $display("FAIL reset_cmo_op got=%b exp=0000", cmo_req_op_o); end
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_fence();
      int acc, nvalid, rsp_at;
      logic [3:0] op_seen;
      logic [SW-1:0] sid_seen;
      logic [TW-1:0] tid_seen;
      logic err_seen;
      nvalid = 0; rsp_at = -1; op_seen = '0; sid_seen = '0; tid_seen = '0; err_seen = 1'bx;
      cmo_req_ready_i = 1'b1; core_rsp_ready_i = 1'b1;
      drive_req(3'b000, 49'h1234, 64'h0, 3'd2, 6'h15, 1'b1, acc);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         core_req_valid_i = 1'b0;
         if (cmo_req_valid_o) begin nvalid++; op_seen = cmo_req_op_o; end
         if (core_rsp_valid_o) begin
            rsp_at = cyc; sid_seen = core_rsp_sid_o; tid_seen = core_rsp_tid_o; err_seen = core_rsp_error_o;
            break;
         end
      end
      total++; if (nvalid != 1) begin bad++; $display("FAIL fence_valid_cycles got=%0d exp=1", nvalid); end
      total++; if (op_seen !== 4'b0001) begin bad++; $display("FAIL fence_op got=%b exp=0001", op_seen); end
      total++; if (rsp_at != acc + 4) begin bad++; $display("FAIL fence_rsp_latency got=%0d exp=%0d", rsp_at - acc, 4); end
      total++; if (sid_seen !== 3'd2) begin bad++; $display("FAIL fence_sid got=%0h exp=2", sid_seen); end
      total++; if (tid_seen !== 6'h15) begin bad++; $display("FAIL fence_tid got=%0h exp=15", tid_seen); end
      total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL fence_error got=%b exp=0", err_seen); end
      @(negedge clk_i);
      total++; if (core_req_ready_o !== 1'b1) begin bad++; $display("FAIL fence_idle_after got=%b exp=1", core_req_ready_o); end
      core_rsp_ready_i = 1'b0;
   endtask

   task automatic test_inval_all_long();
      int acc, rsp_at, lowcnt, busy_viol;
      bit hs;
      rsp_at = -1; lowcnt = 0; busy_viol = 0; hs = 0;
      cmo_req_ready_i = 1'b1; core_rsp_ready_i = 1'b1;
      drive_req(3'b011, 49'h0, 64'h0, 3'd5, 6'h2A, 1'b1, acc);
      for (int c = 0; c < 200; c++) begin
         @(negedge clk_i);
         core_req_valid_i = 1'b0;
         if (hs) begin
            cmo_req_ready_i = (lowcnt < 128) ? 1'b0 : 1'b1;
            lowcnt++;
         end else if (cmo_req_valid_o) hs = 1;
         if (core_req_ready_o !== 1'b0) busy_viol++;
         if (core_rsp_valid_o) begin rsp_at = cyc; break; end
      end
      total++; if (rsp_at != acc + 131) begin bad++; $display("FAIL inval_all_rsp_latency got=%0d exp=131", rsp_at - acc); end
      total++; if (busy_viol != 0) begin bad++; $display("FAIL inval_all_req_ready_busy got=%0d exp=0", busy_viol); end
      @(negedge clk_i);
      core_rsp_ready_i = 1'b0;
   endtask

   task automatic test_set_backpressure();
      int acc, nvalid, stable_viol, idle_at;
      bit rsp_seen;
      nvalid = 0; stable_viol = 0; idle_at = -1; rsp_seen = 0;
      cmo_req_ready_i = 1'b0; core_rsp_ready_i = 1'b1;
      drive_req(3'b010, 49'h1000, 64'hF0, 3'd1, 6'h03, 1'b0, acc);
      for (int c = 0; c < 30; c++) begin
         @(negedge clk_i);
         core_req_valid_i = 1'b0;
         if (core_req_ready_o) begin idle_at = cyc; break; end
         if (core_rsp_valid_o) rsp_seen = 1;
         if (cmo_req_valid_o) begin
            nvalid++;
            if (cmo_req_addr_o !== 49'h1000 || cmo_req_wdata_o !== 64'hF0 || cmo_req_op_o !== 4'b0100)
               stable_viol++;
            cmo_req_ready_i = (nvalid >= 6) ? 1'b1 : 1'b0;
         end
      end
      total++; if (nvalid != 6) begin bad++; $display("FAIL set_valid_cycles got=%0d exp=6", nvalid); end
      total++; if (stable_viol != 0) begin bad++; $display("FAIL set_payload_stable got=%0d exp=0", stable_viol); end
      total++; if (idle_at != acc + 9) begin bad++; $display("FAIL set_idle_latency got=%0d exp=9", idle_at - acc); end
      total++; if (rsp_seen !== 1'b0) begin bad++; $display("FAIL set_no_rsp got=%b exp=0", rsp_seen); end
      cmo_req_ready_i = 1'b1;
   endtask

   task automatic test_illegal();
      int acc, rsp_at, cmo_cnt, rsp_cnt;
      logic err_seen;
      rsp_at = -1; cmo_cnt = 0; rsp_cnt = 0; err_seen = 1'bx;
      core_rsp_ready_i = 1'b1;
      drive_req(3'b110, 49'h55, 64'h1, 3'd4, 6'h3F, 1'b1, acc);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         core_req_valid_i = 1'b0;
         if (cmo_req_valid_o) cmo_cnt++;
         if (core_rsp_valid_o && rsp_at < 0) begin rsp_at = cyc; err_seen = core_rsp_error_o; end
      end
      total++; if (rsp_at != acc + 1) begin bad++; $display("FAIL illegal_rsp_latency got=%0d exp=1", rsp_at - acc); end
      total++; if (err_seen !== 1'b1) begin bad++; $display("FAIL illegal_rsp_error got=%b exp=1", err_seen); end
      drive_req(3'b111, 49'h66, 64'h2, 3'd6, 6'h01, 1'b0, acc);
      @(negedge clk_i);
      core_req_valid_i = 1'b0;
      total++; if (core_req_ready_o !== 1'b1) begin bad++; $display("FAIL illegal_noresp_idle got=%b exp=1", core_req_ready_o); end
      for (int c = 0; c < 5; c++) begin
         if (cmo_req_valid_o) cmo_cnt++;
         if (core_rsp_valid_o) rsp_cnt++;
         @(negedge clk_i);
      end
      total++; if (cmo_cnt != 0) begin bad++; $display("FAIL illegal_no_cmo got=%0d exp=0", cmo_cnt); end
      total++; if (rsp_cnt != 0) begin bad++; $display("FAIL illegal_noresp_rsp got=%0d exp=0", rsp_cnt); end
      core_rsp_ready_i = 1'b0;
   endtask

   task automatic test_rsp_backpressure();
      int acc, rsp_at, viol;
      rsp_at = -1; viol = 0;
      cmo_req_ready_i = 1'b1; core_rsp_ready_i = 1'b0;
      drive_req(3'b001, 49'hABC0, 64'h7, 3'd3, 6'h2C, 1'b1, acc);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         core_req_valid_i = 1'b0;
         if (core_rsp_valid_o) begin rsp_at = cyc; break; end
      end
      total++; if (rsp_at != acc + 4) begin bad++; $display("FAIL bp_rsp_latency got=%0d exp=4", rsp_at - acc); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         if (core_rsp_valid_o !== 1'b1 || core_rsp_sid_o !== 3'd3 || core_rsp_tid_o !== 6'h2C ||
             core_rsp_error_o !== 1'b0 || core_req_ready_o !== 1'b0)
            viol++;
      end
      total++; if (viol != 0) begin bad++; $display("FAIL bp_rsp_stable got=%0d exp=0", viol); end
      core_rsp_ready_i = 1'b1;
      @(negedge clk_i);
      total++; if (core_req_ready_o !== 1'b1 || core_rsp_valid_o !== 1'b0) begin
         bad++; $display("FAIL bp_release got=%b%b exp=10", core_req_ready_o, core_rsp_valid_o);
      end
      core_rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      int acc, idle_at;
      idle_at = -1;
      cmo_req_ready_i = 1'b1; core_rsp_ready_i = 1'b0;
      drive_req(3'b011, 49'h0, 64'hFF, 3'd7, 6'h11, 1'b1, acc);
      @(negedge clk_i); core_req_valid_i = 1'b0;
      @(negedge clk_i); cmo_req_ready_i = 1'b0;
      @(negedge clk_i);
      total++; if (core_req_ready_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", core_req_ready_o); end
      #1 rst_i = 1'b1;
      #1;
      total++; if (core_req_ready_o !== 1'b1 || cmo_req_valid_o !== 1'b0 || core_rsp_valid_o !== 1'b0 ||
                   core_rsp_error_o !== 1'b0 || cmo_req_op_o !== 4'b0000) begin
         bad++; $display("FAIL midrst_async got=%b%b%b%b%b exp=10000", core_req_ready_o, cmo_req_valid_o,
                         core_rsp_valid_o, core_rsp_error_o, |cmo_req_op_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0; cmo_req_ready_i = 1'b1; core_rsp_ready_i = 1'b1;
      @(negedge clk_i);
      drive_req(3'b000, 49'h0, 64'h0, 3'd0, 6'h00, 1'b1, acc);
      @(negedge clk_i);
      core_req_valid_i = 1'b0;
      total++; if (cmo_req_valid_o !== 1'b1 || cmo_req_op_o !== 4'b0001) begin
         bad++; $display("FAIL midrst_fence_accept got=%b/%b exp=1/0001", cmo_req_valid_o, cmo_req_op_o);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         if (core_req_ready_o) begin idle_at = cyc; break; end
      end
      total++; if (idle_at != acc + 5) begin bad++; $display("FAIL midrst_fence_done got=%0d exp=5", idle_at - acc); end
      core_rsp_ready_i = 1'b0;
   endtask

   // Reference: rsp at accept+4+stall+max(busy-1,0); next request at rsp handshake+1
   task automatic test_random();
      int unsigned opc;
      logic nr;
      logic [AW-1:0] ad;
      logic [WW-1:0] wd;
      logic [SW-1:0] sd;
      logic [TW-1:0] td;
      logic [3:0] exp_op;
      int acc, s, b, r, exp_rsp, exp_idle, stall, busy, rwait, rsp_at, idle_at, viol;
      bit legal, hs, cmo_seen, finished;
      viol = 0;
      for (int n = 0; n < 40; n++) begin
         opc   = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
         legal = (opc < 4);
         nr    = 1'($urandom_range(0, 1));
         ad    = AW'({$urandom, $urandom});
         wd    = {$urandom, $urandom};
         sd    = SW'($urandom);
         td    = TW'($urandom);
         exp_op = 4'd1 << opc;
         s = $urandom_range(0, 3); b = $urandom_range(0, 6); r = $urandom_range(0, 3);
         stall = s; busy = b; rwait = r;
         hs = 0; cmo_seen = 0; finished = 0; rsp_at = -1; idle_at = -1;
         cmo_req_ready_i = 1'b1; core_rsp_ready_i = 1'b0;
         total++; if (core_req_ready_o !== 1'b1) begin bad++; $display("FAIL rnd_start_idle n=%0d got=%b exp=1", n, core_req_ready_o); end
         drive_req(3'(opc), ad, wd, sd, td, nr, acc);
         exp_rsp  = legal ? acc + 4 + s + ((b > 0) ? b - 1 : 0) : acc + 1;
         exp_idle = nr ? exp_rsp + r + 1 : exp_rsp;
         for (int c = 0; c < 100; c++) begin
            @(negedge clk_i);
            core_req_valid_i = 1'b0;
            if (core_req_ready_o) begin finished = 1; idle_at = cyc; break; end
            if (!cmo_req_valid_o && cmo_req_op_o !== 4'b0000) viol++;
            if (hs) begin
               cmo_req_ready_i = (busy == 0);
               if (busy > 0) busy--;
            end else if (cmo_req_valid_o) begin
               cmo_seen = 1;
               if (cmo_req_op_o !== exp_op || cmo_req_addr_o !== ad || cmo_req_wdata_o !== wd) viol++;
               if (stall > 0) begin cmo_req_ready_i = 1'b0; stall--; end
               else begin cmo_req_ready_i = 1'b1; hs = 1; end
            end else cmo_req_ready_i = 1'b1;
            if (core_rsp_valid_o) begin
               if (rsp_at < 0) rsp_at = cyc;
               if (core_rsp_sid_o !== sd || core_rsp_tid_o !== td || core_rsp_error_o !== !legal) viol++;
               if (rwait > 0) begin core_rsp_ready_i = 1'b0; rwait--; end
               else core_rsp_ready_i = 1'b1;
            end
         end
         if (!finished) begin
            total++; bad++;
            $display("FAIL rnd_timeout n=%0d got=busy exp=idle", n);
         end else begin
            total++; if (cmo_seen != legal) begin bad++; $display("FAIL rnd_cmo_issue n=%0d op=%0d got=%0d exp=%0d", n, opc, cmo_seen, legal); end
            total++; if (rsp_at != (nr ? exp_rsp : -1)) begin
               bad++; $display("FAIL rnd_rsp_cycle n=%0d got=%0d exp=%0d", n, rsp_at, nr ? exp_rsp : -1);
            end
            total++; if (idle_at != exp_idle) begin bad++; $display("FAIL rnd_idle_cycle n=%0d got=%0d exp=%0d", n, idle_at, exp_idle); end
         end
      end
      total++; if (viol != 0) begin bad++; $display("FAIL rnd_payload got=%0d exp=0", viol); end
      core_rsp_ready_i = 1'b0;
      cmo_req_ready_i = 1'b1;
   endtask

   initial begin
      test_reset();
      test_fence();
      test_inval_all_long();
      test_set_backpressure();
      test_illegal();
      test_rsp_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
